// File: rtl/hack_alu_pkg.sv
// rtl/hack_alu_pkg.sv - shared width, control-word type and Hack ALU encodings
package hack_alu_pkg;

  localparam int HACK_WIDTH = 16;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam alu_ctrl_t ALU_ZERO    = 6'b101010;
  localparam alu_ctrl_t ALU_ONE     = 6'b111111;
  localparam alu_ctrl_t ALU_NEGONE  = 6'b111010;
  localparam alu_ctrl_t ALU_X       = 6'b001100;
  localparam alu_ctrl_t ALU_Y       = 6'b110000;
  localparam alu_ctrl_t ALU_NOTX    = 6'b001101;
  localparam alu_ctrl_t ALU_NOTY    = 6'b110001;
  localparam alu_ctrl_t ALU_NEGX    = 6'b001111;
  localparam alu_ctrl_t ALU_NEGY    = 6'b110011;
  localparam alu_ctrl_t ALU_XPLUS1  = 6'b011111;
  localparam alu_ctrl_t ALU_YPLUS1  = 6'b110111;
  localparam alu_ctrl_t ALU_XMINUS1 = 6'b001110;
  localparam alu_ctrl_t ALU_YMINUS1 = 6'b110010;
  localparam alu_ctrl_t ALU_XPLUSY  = 6'b000010;
  localparam alu_ctrl_t ALU_XMINUSY = 6'b010011;
  localparam alu_ctrl_t ALU_YMINUSX = 6'b000111;
  localparam alu_ctrl_t ALU_XANDY   = 6'b000000;
  localparam alu_ctrl_t ALU_XORY    = 6'b010101;

endpackage

// File: rtl/hack_alu_core.sv
// rtl/hack_alu_core.sv - combinational Hack ALU datapath (zero/negate, add/and, negate)
module hack_alu_core
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = HACK_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  alu_ctrl_t        ctrl,
  output logic [WIDTH-1:0] o
);

  logic [WIDTH-1:0] w_x1;
  logic [WIDTH-1:0] w_x2;
  logic [WIDTH-1:0] w_y1;
  logic [WIDTH-1:0] w_y2;
  logic [WIDTH-1:0] w_r;

  assign w_x1 = ctrl.zx ? '0 : x;
  assign w_x2 = ctrl.nx ? ~w_x1 : w_x1;
  assign w_y1 = ctrl.zy ? '0 : y;
  assign w_y2 = ctrl.ny ? ~w_y1 : w_y1;

  // Sum truncates to WIDTH bits; the carry out is intentionally dropped.
  assign w_r = ctrl.f ? (w_x2 + w_y2) : (w_x2 & w_y2);
  assign o   = ctrl.no ? ~w_r : w_r;

endmodule

// File: rtl/hack_alu.sv
// rtl/hack_alu.sv - Hack ALU with one-cycle registered result, flags and valid
module hack_alu
  import hack_alu_pkg::*;
#(
  parameter int WIDTH = HACK_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);

  alu_ctrl_t        w_ctrl;
  logic [WIDTH-1:0] w_o;

  logic             r_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;

  assign w_ctrl = '{zx: zx, nx: nx, zy: zy, ny: ny, f: f, no: no};

  hack_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .x    (x),
    .y    (y),
    .ctrl (w_ctrl),
    .o    (w_o)
  );

  // Flags come from the same combinational result that is captured, so they
  // can never disagree with the registered out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_zr    <= 1'b1;
      r_ng    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_o;
        r_zr  <= (w_o == '0);
        r_ng  <= w_o[WIDTH-1];
      end
    end
  end

  assign out_valid = r_valid;
  assign out       = r_out;
  assign zr        = r_zr;
  assign ng        = r_ng;

endmodule

// File: tb/tb_hack_alu.sv
// tb/tb_hack_alu.sv - directed self-checking bench for hack_alu
module tb_hack_alu;
  import hack_alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] x;
  logic [15:0] y;
  logic        zx, nx, zy, ny, f, no;
  logic        out_valid;
  logic [15:0] out;
  logic        zr;
  logic        ng;

  int n_checks;
  int n_fails;

  hack_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .zx        (zx),
    .nx        (nx),
    .zy        (zy),
    .ny        (ny),
    .f         (f),
    .no        (no),
    .out_valid (out_valid),
    .out       (out),
    .zr        (zr),
    .ng        (ng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] exp_out, input logic exp_zr,
                              input logic exp_ng, input logic exp_valid);
    check({tag, ".out"}, {16'h0, out}, {16'h0, exp_out});
    check({tag, ".zr"}, {31'h0, zr}, {31'h0, exp_zr});
    check({tag, ".ng"}, {31'h0, ng}, {31'h0, exp_ng});
    check({tag, ".valid"}, {31'h0, out_valid}, {31'h0, exp_valid});
  endtask

  // Drive one op at the falling edge, then sample 1 time unit after the capturing edge.
  task automatic apply(input logic [5:0] ctrl, input logic [15:0] xv, input logic [15:0] yv);
    @(negedge clk);
    {zx, nx, zy, ny, f, no} = ctrl;
    x        = xv;
    y        = yv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  ctrl;
    logic [15:0] exp;
  } vec_t;

  vec_t canon[18];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    x        = 16'h0;
    y        = 16'h0;
    {zx, nx, zy, ny, f, no} = 6'b0;

    // x=3, y=5 for every canonical encoding, expected values worked by hand
    canon[0]  = '{"zero",   ALU_ZERO,    16'h0000};
    canon[1]  = '{"one",    ALU_ONE,     16'h0001};
    canon[2]  = '{"negone", ALU_NEGONE,  16'hFFFF};
    canon[3]  = '{"x",      ALU_X,       16'h0003};
    canon[4]  = '{"y",      ALU_Y,       16'h0005};
    canon[5]  = '{"notx",   ALU_NOTX,    16'hFFFC};
    canon[6]  = '{"noty",   ALU_NOTY,    16'hFFFA};
    canon[7]  = '{"negx",   ALU_NEGX,    16'hFFFD};
    canon[8]  = '{"negy",   ALU_NEGY,    16'hFFFB};
    canon[9]  = '{"xp1",    ALU_XPLUS1,  16'h0004};
    canon[10] = '{"yp1",    ALU_YPLUS1,  16'h0006};
    canon[11] = '{"xm1",    ALU_XMINUS1, 16'h0002};
    canon[12] = '{"ym1",    ALU_YMINUS1, 16'h0004};
    canon[13] = '{"xpy",    ALU_XPLUSY,  16'h0008};
    canon[14] = '{"xmy",    ALU_XMINUSY, 16'hFFFE};
    canon[15] = '{"ymx",    ALU_YMINUSX, 16'h0002};
    canon[16] = '{"xandy",  ALU_XANDY,   16'h0001};
    canon[17] = '{"xory",   ALU_XORY,    16'h0007};

    // Asynchronous reset asserted between edges
    #12;
    rst_n = 1'b0;
    #1;
    check_result("reset_async", 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    apply(6'b011111, 16'h0001, 16'h0002);
    check_result("xplus1", 16'h0002, 1'b0, 1'b0, 1'b1);

    apply(6'b010011, 16'h0003, 16'h0005);
    check_result("xminusy", 16'hFFFE, 1'b0, 1'b1, 1'b1);
    apply(6'b000111, 16'h0003, 16'h0005);
    check_result("yminusx", 16'h0002, 1'b0, 1'b0, 1'b1);

    apply(6'b101010, 16'h1234, 16'h5678);
    check_result("const0", 16'h0000, 1'b1, 1'b0, 1'b1);
    apply(6'b111111, 16'h1234, 16'h5678);
    check_result("const1", 16'h0001, 1'b0, 1'b0, 1'b1);
    apply(6'b111010, 16'h1234, 16'h5678);
    check_result("constm1", 16'hFFFF, 1'b0, 1'b1, 1'b1);

    apply(6'b000000, 16'h00F0, 16'h0F0F);
    check_result("and", 16'h0000, 1'b1, 1'b0, 1'b1);
    apply(6'b010101, 16'h00F0, 16'h0F0F);
    check_result("or", 16'h0FFF, 1'b0, 1'b0, 1'b1);

    apply(6'b011111, 16'h7FFF, 16'h0000);
    check_result("wrap_pos", 16'h8000, 1'b0, 1'b1, 1'b1);
    apply(6'b011111, 16'hFFFF, 16'h0000);
    check_result("wrap_zero", 16'h0000, 1'b1, 1'b0, 1'b1);

    // All 18 canonical encodings streamed back-to-back
    for (int i = 0; i < 18; i++) begin
      apply(canon[i].ctrl, 16'h0003, 16'h0005);
      check_result(canon[i].name, canon[i].exp, canon[i].exp == 16'h0, canon[i].exp[15], 1'b1);
    end

    // Idle: valid drops, result holds the last value (x|y = 7)
    idle();
    check_result("hold1", 16'h0007, 1'b0, 1'b0, 1'b0);
    idle();
    check_result("hold2", 16'h0007, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-stream, between edges
    apply(6'b010011, 16'h0003, 16'h0005);
    check_result("pre_reset", 16'hFFFE, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_result("reset_mid", 16'h0000, 1'b1, 1'b0, 1'b0);
    // in_valid stays high across an edge while reset is held: nothing captured
    @(posedge clk);
    #1;
    check_result("reset_held", 16'h0000, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    apply(6'b000010, 16'h1111, 16'h2222);
    check_result("after_reset", 16'h3333, 1'b0, 1'b0, 1'b1);
    idle();
    check_result("after_idle", 16'h3333, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hack_alu.md
Name: hack_alu

Overview:
- Registered implementation of the nand2tetris Hack ALU.
- Computes one of the Hack functions of two WIDTH-bit operands, selected by six control bits (zx, nx, zy, ny, f, no).
- Produces the result plus zero (zr) and negative (ng) flags.
- Sits between the CPU register file (A/D/M operands) and the writeback path; one-cycle registered latency with valid qualifiers.

Parameters:
- WIDTH, 16, operand/result width in bits (two's complement).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/controls valid this cycle.
- x  input  WIDTH  operand X.
- y  input  WIDTH  operand Y.
- zx  input  1  zero X.
- nx  input  1  bitwise-negate X (after zx).
- zy  input  1  zero Y.
- ny  input  1  bitwise-negate Y (after zy).
- f  input  1  1: X+Y, 0: X&Y.
- no  input  1  bitwise-negate result.
- out_valid  output  1  registered result valid.
- out  output  WIDTH  result.
- zr  output  1  1 when out == 0.
- ng  output  1  1 when out[WIDTH-1] == 1.

Behaviour:
- Combinational core, in order:
  - x1 = zx ? 0 : x; x2 = nx ? ~x1 : x1.
  - y1 = zy ? 0 : y; y2 = ny ? ~y1 : y1.
  - r = f ? (x2 + y2) mod 2^WIDTH : (x2 & y2); carry out discarded, no overflow flag.
  - o = no ? ~r : r.
- Register stage:
  - On a rising clk edge with in_valid=1: out<=o, zr<=(o==0), ng<=o[WIDTH-1], out_valid<=1.
  - With in_valid=0: out/zr/ng hold their previous values; out_valid<=0.
- Latency: exactly 1 cycle; throughput 1 result per cycle (back-to-back in_valid accepted); no backpressure.
- Reset (rst_n=0, asynchronous, any time including mid-stream):
  - out=0, zr=1, ng=0, out_valid=0 immediately.
  - A transaction presented in the same cycle reset releases is not captured unless rst_n is high at that clock edge.
- zr and ng are always consistent with the registered out (derived from o, not recomputed from stale data).
- All 64 control combinations are legal; the 18 canonical Hack encodings must give their standard results:
  - 0, 1, -1
  - x, y, !x, !y, -x, -y
  - x+1, y+1, x-1, y-1
  - x+y, x-y, y-x
  - x&y, x|y
- Wrap-around: 0x7FFF+1 yields 0x8000 with ng=1; 0xFFFF+1 yields 0 with zr=1.

Decomposition:
- Shared package hack_alu_pkg:
  - WIDTH default.
  - 6-bit control-word type ordered {zx,nx,zy,ny,f,no}.
  - Named localparams for the 18 Hack encodings (e.g. ALU_ZERO=101010, ALU_ONE=111111, ALU_XPLUS1=011111, ALU_XMINUSY=010011, ALU_XANDY=000000, ALU_XORY=010101).
- One sub-module: hack_alu_core, purely combinational (x, y, controls -> o), instantiated by hack_alu, which adds the register stage and valid/flag logic.

Test Plan:
- Reset: assert rst_n=0 asynchronously between clock edges -> out=0, zr=1, ng=0, out_valid=0 without waiting for a clock edge.
- x+1: x=0x0001, y=0x0002, controls 011111, in_valid=1 -> next cycle out=0x0002, zr=0, ng=0, out_valid=1.
- x-y and y-x:
  - x=0x0003, y=0x0005, controls 010011 -> out=0xFFFE, ng=1, zr=0.
  - Same operands, controls 000111 -> out=0x0002.
- Constants and logic:
  - Controls 101010 -> out=0, zr=1; 111111 -> out=1; 111010 -> out=0xFFFF, ng=1.
  - x=0x00F0, y=0x0F0F: 000000 -> 0x0000, zr=1; 010101 -> 0x0FFF.
- Wrap-around: x=0x7FFF, controls 011111 -> out=0x8000, ng=1. Then x=0xFFFF, same controls -> out=0, zr=1.
- Streaming/hold and reset mid-stream:
  - Three back-to-back valid ops -> three consecutive correct results with out_valid high.
  - Then in_valid=0 -> out_valid=0 and out holds the last value.
  - Assert rst_n mid-stream -> outputs return to reset values; the first valid op after release produces a correct result one cycle later.
